// File: rtl/uart_rx_fifo_ctrl_if.sv
// Signal bundle between the UART receiver / APB read path and uart_rx_fifo_ctrl.
// err_drop_cnt exists only when UART_RX_ERR_DROP_EN is defined.
interface uart_rx_fifo_ctrl_if #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
);
    logic          rx_en;
    logic          tick;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          parity_err;
    logic          stop_bit_err;
    logic          rd_en;
    logic          flush;
    logic [AW:0]   thresh;
    logic          overrun_clr;
    logic [7:0]    rd_data;
    logic [1:0]    rd_err;
    logic          fifo_empty;
    logic          fifo_full;
    logic [AW:0]   fifo_count;
    logic          rts_n;
    logic          overrun;
    logic          irq_thresh;
    logic          irq_timeout;
`ifdef UART_RX_ERR_DROP_EN
    logic [7:0]    err_drop_cnt;
`endif

    modport master (
        output rx_en, tick, rx_valid, rx_data, parity_err, stop_bit_err,
        output rd_en, flush, thresh, overrun_clr,
`ifdef UART_RX_ERR_DROP_EN
        input  err_drop_cnt,
`endif
        input  rd_data, rd_err, fifo_empty, fifo_full, fifo_count,
        input  rts_n, overrun, irq_thresh, irq_timeout
    );

    modport slave (
        input  rx_en, tick, rx_valid, rx_data, parity_err, stop_bit_err,
        input  rd_en, flush, thresh, overrun_clr,
`ifdef UART_RX_ERR_DROP_EN
        output err_drop_cnt,
`endif
        output rd_data, rd_err, fifo_empty, fifo_full, fifo_count,
        output rts_n, overrun, irq_thresh, irq_timeout
    );
endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive FIFO with RTS hysteresis, threshold/timeout interrupts and sticky overrun.
// Optional: UART_RX_ERR_DROP_EN drops errored frames and counts them instead of storing flags.
module uart_rx_fifo_ctrl #(
    parameter int DEPTH         = 16,
    parameter int AW            = $clog2(DEPTH),
    parameter int RTS_HI        = DEPTH - 2,
    parameter int RTS_LO        = DEPTH / 2,
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic               clk,
    input  logic               reset,
    uart_rx_fifo_ctrl_if.slave bus
);
`ifdef UART_RX_ERR_DROP_EN
    localparam int WW = 8;
`else
    localparam int WW = 10;
`endif
    localparam int            TW       = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_HI   = (AW+1)'(RTS_HI);
    localparam logic [AW:0]   CNT_LO   = (AW+1)'(RTS_LO);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_TICKS);

    logic [WW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_next;
    logic          push_q;
    logic          empty;
    logic          full;
    logic          wr_req;
    logic          wr_go;
    logic          rd_go;
    logic          ovf_evt;
    logic [WW-1:0] wr_word;
    logic          rts_n_q;
    logic          overrun_q;
    logic          irq_thresh_q;
    logic          irq_timeout_q;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

`ifdef UART_RX_ERR_DROP_EN
    logic       drop_evt;
    logic [7:0] drop_cnt;

    assign wr_word  = bus.rx_data;
    assign wr_req   = push_q && bus.rx_en && !bus.flush && !(bus.parity_err || bus.stop_bit_err);
    assign drop_evt = push_q && bus.rx_en && !bus.flush && (bus.parity_err || bus.stop_bit_err);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (bus.flush) begin
            drop_cnt <= '0;
        end else if (drop_evt && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign bus.err_drop_cnt = drop_cnt;
    assign bus.rd_err       = 2'b00;
    assign bus.rd_data      = empty ? 8'h00 : mem[rd_ptr];
`else
    assign wr_word     = {bus.stop_bit_err, bus.parity_err, bus.rx_data};
    assign wr_req      = push_q && bus.rx_en && !bus.flush;
    assign bus.rd_err  = empty ? 2'b00 : mem[rd_ptr][9:8];
    assign bus.rd_data = empty ? 8'h00 : mem[rd_ptr][7:0];
`endif

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign rd_go   = bus.rd_en && !empty && !bus.flush;
    assign wr_go   = wr_req && (!full || rd_go);
    assign ovf_evt = wr_req && full && !rd_go;

    always_comb begin
        count_next = count;
        if (bus.flush) begin
            count_next = '0;
        end else if (wr_go && !rd_go) begin
            count_next = count + (AW+1)'(1);
        end else if (rd_go && !wr_go) begin
            count_next = count - (AW+1)'(1);
        end
    end

    always_comb begin
        tmo_next = tmo_cnt;
        if (bus.flush || wr_go || rd_go || empty) begin
            tmo_next = '0;
        end else if (bus.tick && tmo_cnt != TMO_MAX) begin
            tmo_next = tmo_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push_q        <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            tmo_cnt       <= '0;
            overrun_q     <= 1'b0;
            rts_n_q       <= 1'b1;
            irq_thresh_q  <= 1'b0;
            irq_timeout_q <= 1'b0;
        end else begin
            push_q  <= bus.rx_valid;
            count   <= count_next;
            tmo_cnt <= tmo_next;
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_go) wr_ptr <= wr_ptr + AW'(1);
                if (rd_go) rd_ptr <= rd_ptr + AW'(1);
            end
            if (ovf_evt) begin
                overrun_q <= 1'b1;
            end else if (bus.overrun_clr) begin
                overrun_q <= 1'b0;
            end
            // Between RTS_LO and RTS_HI the previous RTS level is kept.
            if (!bus.rx_en || count >= CNT_HI) begin
                rts_n_q <= 1'b1;
            end else if (count <= CNT_LO) begin
                rts_n_q <= 1'b0;
            end
            irq_thresh_q  <= (bus.thresh != '0) && (count >= bus.thresh);
            irq_timeout_q <= (tmo_next == TMO_MAX) && (count_next != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_go) mem[wr_ptr] <= wr_word;
    end

    assign bus.fifo_empty  = empty;
    assign bus.fifo_full   = full;
    assign bus.fifo_count  = count;
    assign bus.rts_n       = rts_n_q;
    assign bus.overrun     = overrun_q;
    assign bus.irq_thresh  = irq_thresh_q;
    assign bus.irq_timeout = irq_timeout_q;
endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Bench for uart_rx_fifo_ctrl: vector table, directed corner sequences and a random run
// against a queue-based reference model. Honours UART_RX_ERR_DROP_EN when defined.
module tb_uart_rx_fifo_ctrl;
    localparam int DEPTH = 16;
    localparam int TMO   = 640;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_rx_fifo_ctrl_if #(.DEPTH(DEPTH)) bus ();
    uart_rx_fifo_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rx_valid;
        logic [7:0] data;
        logic       rd_en;
        int         exp_count;
        logic       exp_empty;
        logic [7:0] exp_data;
        logic       exp_thr;
    } vec_t;
    vec_t tbl[7];

    logic [9:0] q[$];
    int   old_size, t_ref, drop_ref;
    logic ov_ref, rts_ref, thr_ref, to_ref, pend_ref;
    logic did_pop, did_push, want, ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic par, input logic stp, input logic clr);
        bus.rx_valid = 1'b1;
        step();
        bus.rx_valid     = 1'b0;
        bus.rx_data      = d;
        bus.parity_err   = par;
        bus.stop_bit_err = stp;
        bus.overrun_clr  = clr;
        step();
        bus.parity_err   = 1'b0;
        bus.stop_bit_err = 1'b0;
        bus.overrun_clr  = 1'b0;
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset            = 1'b1;
        bus.rx_en        = 1'b1;
        bus.tick         = 1'b0;
        bus.rx_valid     = 1'b0;
        bus.rx_data      = 8'h00;
        bus.parity_err   = 1'b0;
        bus.stop_bit_err = 1'b0;
        bus.rd_en        = 1'b0;
        bus.flush        = 1'b0;
        bus.thresh       = '0;
        bus.overrun_clr  = 1'b0;

        tbl[0] = '{1'b1, 8'h00, 1'b0, 0, 1'b1, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 8'h5A, 1'b0, 1, 1'b0, 8'h5A, 1'b0};
        tbl[2] = '{1'b1, 8'h00, 1'b0, 1, 1'b0, 8'h5A, 1'b0};
        tbl[3] = '{1'b0, 8'hA5, 1'b0, 2, 1'b0, 8'h5A, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 8'hA5, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h00, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h00, 1'b0};

        step();
        step();
        chk("reset_count", 32'(bus.fifo_count), 0);
        chk("reset_empty", 32'(bus.fifo_empty), 1);
        chk("reset_full", 32'(bus.fifo_full), 0);
        chk("reset_overrun", 32'(bus.overrun), 0);
        chk("reset_rts", 32'(bus.rts_n), 1);
        chk("reset_irq_thr", 32'(bus.irq_thresh), 0);
        chk("reset_irq_to", 32'(bus.irq_timeout), 0);
        chk("reset_rd_data", 32'(bus.rd_data), 0);
        chk("reset_rd_err", 32'(bus.rd_err), 0);
        reset = 1'b0;
        step();
        chk("rts_after_release", 32'(bus.rts_n), 0);

        // Vector table: two pushes, two pops, one pop on empty; threshold 2.
        bus.thresh = 5'd2;
        for (int i = 0; i < 7; i++) begin
            bus.rx_valid = tbl[i].rx_valid;
            bus.rx_data  = tbl[i].data;
            bus.rd_en    = tbl[i].rd_en;
            step();
            chk($sformatf("tbl%0d_count", i), 32'(bus.fifo_count), 32'(tbl[i].exp_count));
            chk($sformatf("tbl%0d_empty", i), 32'(bus.fifo_empty), 32'(tbl[i].exp_empty));
            chk($sformatf("tbl%0d_thr", i), 32'(bus.irq_thresh), 32'(tbl[i].exp_thr));
            if (!tbl[i].exp_empty)
                chk($sformatf("tbl%0d_data", i), 32'(bus.rd_data), 32'(tbl[i].exp_data));
        end
        bus.rx_valid = 1'b0;
        bus.rd_en    = 1'b0;
        bus.thresh   = '0;

        // Errored frame
        push_byte(8'h7E, 1'b1, 1'b0, 1'b0);
`ifdef UART_RX_ERR_DROP_EN
        chk("perr_count", 32'(bus.fifo_count), 0);
        chk("perr_drop_cnt", 32'(bus.err_drop_cnt), 1);
        chk("perr_overrun", 32'(bus.overrun), 0);
`else
        chk("perr_count", 32'(bus.fifo_count), 1);
        chk("perr_rd_data", 32'(bus.rd_data), 32'h7E);
        chk("perr_rd_err", 32'(bus.rd_err), 1);
`endif
        do_flush();
        chk("flush_count", 32'(bus.fifo_count), 0);

        // Overrun and full-FIFO corner cases
        for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        chk("fill_full", 32'(bus.fifo_full), 1);
        chk("fill_count", 32'(bus.fifo_count), 16);
        chk("fill_overrun", 32'(bus.overrun), 0);
        push_byte(8'h33, 1'b0, 1'b0, 1'b0);
        chk("ovr_set", 32'(bus.overrun), 1);
        chk("ovr_count", 32'(bus.fifo_count), 16);
        chk("ovr_head", 32'(bus.rd_data), 32'h10);
        push_byte(8'h44, 1'b0, 1'b0, 1'b1);
        chk("ovr_set_wins_clr", 32'(bus.overrun), 1);
        bus.overrun_clr = 1'b1;
        step();
        bus.overrun_clr = 1'b0;
        chk("ovr_clr", 32'(bus.overrun), 0);
        bus.rx_valid = 1'b1;
        step();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h55;
        bus.rd_en    = 1'b1;
        step();
        bus.rd_en = 1'b0;
        chk("full_pushpop_count", 32'(bus.fifo_count), 16);
        chk("full_pushpop_head", 32'(bus.rd_data), 32'h11);
        chk("full_pushpop_ovr", 32'(bus.overrun), 0);
        push_byte(8'h66, 1'b0, 1'b0, 1'b0);
        chk("ovr_again", 32'(bus.overrun), 1);
        for (int i = 0; i < 11; i++) pop();
        chk("drain5_count", 32'(bus.fifo_count), 5);
        chk("drain5_head", 32'(bus.rd_data), 32'h1C);

        // Asynchronous reset in the middle of a push
        bus.rx_valid = 1'b1;
        step();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h99;
        reset = 1'b1;
        #1;
        chk("arst_count", 32'(bus.fifo_count), 0);
        chk("arst_rts", 32'(bus.rts_n), 1);
        chk("arst_overrun", 32'(bus.overrun), 0);
        chk("arst_empty", 32'(bus.fifo_empty), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        chk("arst_push_lost", 32'(bus.fifo_count), 0);
        chk("arst_rts_release", 32'(bus.rts_n), 0);

        // RTS hysteresis and threshold interrupt
        bus.thresh = 5'd10;
        for (int i = 0; i < 13; i++) push_byte(8'(i), 1'b0, 1'b0, 1'b0);
        step();
        chk("rts_13", 32'(bus.rts_n), 0);
        chk("thr_13", 32'(bus.irq_thresh), 1);
        push_byte(8'hEE, 1'b0, 1'b0, 1'b0);
        step();
        chk("rts_14", 32'(bus.rts_n), 1);
        for (int i = 0; i < 5; i++) pop();
        step();
        chk("rts_9", 32'(bus.rts_n), 1);
        chk("thr_9", 32'(bus.irq_thresh), 0);
        pop();
        step();
        chk("rts_8", 32'(bus.rts_n), 0);
        bus.thresh = '0;
        do_flush();

        // Receive idle timeout
        push_byte(8'hA1, 1'b0, 1'b0, 1'b0);
        bus.tick = 1'b1;
        repeat (TMO - 1) step();
        bus.tick = 1'b0;
        step();
        step();
        chk("tmo_639", 32'(bus.irq_timeout), 0);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        step();
        chk("tmo_640", 32'(bus.irq_timeout), 1);
        pop();
        chk("tmo_pop_irq", 32'(bus.irq_timeout), 0);
        chk("tmo_pop_empty", 32'(bus.fifo_empty), 1);

        // Random run against the reference model
        bus.flush       = 1'b1;
        bus.overrun_clr = 1'b1;
        step();
        bus.flush       = 1'b0;
        bus.overrun_clr = 1'b0;
        step();
        q.delete();
        t_ref    = 0;
        drop_ref = 0;
        ov_ref   = 1'b0;
        rts_ref  = 1'b0;
        thr_ref  = 1'b0;
        to_ref   = 1'b0;
        pend_ref = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.rx_valid     = ($urandom_range(0, 99) < 35);
            bus.rx_data      = 8'($urandom);
            bus.parity_err   = ($urandom_range(0, 7) == 0);
            bus.stop_bit_err = ($urandom_range(0, 7) == 0);
            bus.rd_en        = ($urandom_range(0, 99) < ((cyc % 600) < 300 ? 20 : 50));
            bus.flush        = ($urandom_range(0, 199) == 0);
            bus.overrun_clr  = ($urandom_range(0, 29) == 0);
            bus.tick         = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) bus.rx_en = ~bus.rx_en;
            if (cyc % 250 == 0) bus.thresh = 5'($urandom_range(0, DEPTH));

            old_size = q.size();
            thr_ref  = (bus.thresh != 0) && (old_size >= int'(bus.thresh));
            if (!bus.rx_en || old_size >= DEPTH - 2) rts_ref = 1'b1;
            else if (old_size <= DEPTH / 2) rts_ref = 1'b0;
            did_pop  = !bus.flush && bus.rd_en && old_size > 0;
            did_push = 1'b0;
            ovf      = 1'b0;
            want     = !bus.flush && pend_ref && bus.rx_en;
`ifdef UART_RX_ERR_DROP_EN
            if (want && (bus.parity_err || bus.stop_bit_err)) begin
                want = 1'b0;
                if (drop_ref < 255) drop_ref++;
            end
            if (bus.flush) drop_ref = 0;
`endif
            if (bus.flush) begin
                q.delete();
            end else begin
                if (did_pop) void'(q.pop_front());
                if (want) begin
                    if (old_size == DEPTH && !did_pop) ovf = 1'b1;
                    else begin
                        q.push_back({bus.stop_bit_err, bus.parity_err, bus.rx_data});
                        did_push = 1'b1;
                    end
                end
            end
            if (ovf) ov_ref = 1'b1;
            else if (bus.overrun_clr) ov_ref = 1'b0;
            if (bus.flush || did_push || did_pop || old_size == 0) t_ref = 0;
            else if (bus.tick && t_ref < TMO) t_ref++;
            to_ref   = (t_ref == TMO) && (q.size() > 0);
            pend_ref = bus.rx_valid;

            step();
            chk("rnd_count", 32'(bus.fifo_count), 32'(q.size()));
            chk("rnd_empty", 32'(bus.fifo_empty), 32'(q.size() == 0));
            chk("rnd_full", 32'(bus.fifo_full), 32'(q.size() == DEPTH));
            chk("rnd_overrun", 32'(bus.overrun), 32'(ov_ref));
            chk("rnd_rts", 32'(bus.rts_n), 32'(rts_ref));
            chk("rnd_irq_thr", 32'(bus.irq_thresh), 32'(thr_ref));
            chk("rnd_irq_to", 32'(bus.irq_timeout), 32'(to_ref));
            if (q.size() > 0) begin
                chk("rnd_rd_data", 32'(bus.rd_data), 32'(q[0][7:0]));
`ifdef UART_RX_ERR_DROP_EN
                chk("rnd_rd_err", 32'(bus.rd_err), 0);
`else
                chk("rnd_rd_err", 32'(bus.rd_err), 32'(q[0][9:8]));
`endif
            end
`ifdef UART_RX_ERR_DROP_EN
            chk("rnd_drop_cnt", 32'(bus.err_drop_cnt), 32'(drop_ref));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo_ctrl.md
Name: uart_rx_fifo_ctrl

Overview:
Buffering and flow-control controller behind the UART receiver. It captures each received frame and its error flags into a DEPTH-entry FIFO, and serves pops from the APB register read path. It drives the active-low RTS that feeds the receiver's rts_ni, and raises threshold, timeout and overrun status for the interrupt block.

Parameters:
DEPTH, 16, number of FIFO entries; power of 2, minimum 4.
AW, $clog2(DEPTH), pointer width.
RTS_HI, DEPTH-2, count at or above which RTS is deasserted.
RTS_LO, DEPTH/2, count at or below which RTS is reasserted.
TIMEOUT_TICKS, 640, idle tick_i count before the timeout interrupt (4 chars x 10 bits x 16).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_en_i  in  1  receive enable
tick_i  in  1  x16 baud tick
rx_valid_i  in  1  one-cycle frame-done pulse from receiver
rx_data_i  in  8  received byte; valid on the cycle after rx_valid_i
parity_err_i  in  1  parity error; valid on the cycle after rx_valid_i
stop_bit_err_i  in  1  stop-bit error; valid on the cycle after rx_valid_i
rd_en_i  in  1  pop request from APB read
flush_i  in  1  synchronous FIFO clear
thresh_i  in  AW+1  interrupt threshold
overrun_clr_i  in  1  clear sticky overrun
rd_data_o  out  8  head byte (first-word fall-through)
rd_err_o  out  2  head error flags: {stop, parity}
fifo_empty_o  out  1  FIFO empty
fifo_full_o  out  1  FIFO full
fifo_count_o  out  AW+1  current occupancy, 0..DEPTH
rts_no  out  1  active-low ready-to-receive
overrun_o  out  1  sticky overrun flag
irq_thresh_o  out  1  level interrupt: count >= thresh_i and thresh_i != 0
irq_timeout_o  out  1  level interrupt: receive idle timeout

Behaviour:
- Reset values: pointers 0, count 0, fifo_empty_o=1, fifo_full_o=0, overrun_o=0, both irqs 0, rts_no=1, rd_data_o/rd_err_o=0.
- Push pipeline: rx_valid_i is registered to push_q.
  - When push_q=1 and rx_en_i=1, {stop_bit_err_i, parity_err_i, rx_data_i} is the write word.
  - When rx_en_i=0, push_q is ignored.
  - A push becomes visible at fifo_count_o on the cycle after push_q, i.e. 2 cycles after rx_valid_i.
- Pop: rd_en_i with fifo_empty_o=0 advances the read pointer.
  - rd_data_o/rd_err_o show the new head on the next cycle.
  - rd_en_i while empty is ignored; pointers are unchanged and no error is flagged.
- Simultaneous push and pop:
  - Not full, not empty: both occur, count unchanged.
  - Empty: push only.
  - Full: both occur, count stays DEPTH, no overrun.
- Overrun: push while full without a pop discards the frame and sets overrun_o.
  - overrun_o holds until overrun_clr_i.
  - If clear and a new overrun occur in the same cycle, set wins.
- Pointer wrap: pointers are AW bits and wrap from DEPTH-1 to 0. Count is tracked separately, AW+1 bits.
- Flush: flush_i clears pointers, count and timeout, and discards a same-cycle push/pop. overrun_o is not affected. Flush has priority over all other operations.
- RTS, registered:
  - rts_no <= 1 when rx_en_i=0 or count >= RTS_HI.
  - rts_no <= 0 when rx_en_i=1 and count <= RTS_LO.
  - Otherwise it holds (hysteresis).
- Timeout counter (width >= $clog2(TIMEOUT_TICKS+1)):
  - Clears on push, pop, flush, or when the FIFO is empty.
  - Otherwise it increments on tick_i and saturates at TIMEOUT_TICKS.
  - irq_timeout_o = (counter == TIMEOUT_TICKS) and not empty, registered.
- irq_thresh_o is registered, 1-cycle latency after the count change.
- Reset asserted mid-frame or mid-pop returns all state to the reset values immediately (asynchronous); a pending push_q is lost.

Optional Feature:
Macro UART_RX_ERR_DROP_EN.
- Defined:
  - Frames with parity_err_i or stop_bit_err_i set are not written.
  - An extra port err_drop_cnt_o (out, 8) counts dropped frames, saturates at 255 and clears on reset/flush_i.
  - rd_err_o is tied to 2'b00.
  - A dropped frame never causes overrun.
- Undefined: errored frames are stored with their flags and err_drop_cnt_o does not exist.

Test Plan:
- Push 0x5A, then 0xA5 (no errors), then pop twice -> rd_data_o 0x5A then 0xA5; count 2->1->0; fifo_empty_o=1 at end.
- Fill 16 entries, push 0x33 -> overrun_o=1, count 16, head byte unchanged. Pulse overrun_clr_i with a simultaneous push while full -> overrun_o stays 1.
- Fill to 14 -> rts_no=1. Pop to 9 -> rts_no still 1. Pop to 8 -> rts_no=0.
- Store one byte and idle 640 ticks -> irq_timeout_o=1. One pop -> irq_timeout_o=0 and fifo_empty_o=1.
- Push with parity_err_i=1, data 0x7E:
  - Macro undefined: rd_err_o=2'b01, rd_data_o 0x7E.
  - Macro defined: count 0, err_drop_cnt_o=1.
- At count 5, assert reset for one cycle during a push -> count 0, rts_no=1, overrun_o=0. rts_no=0 after release with rx_en_i=1.
